// File: rtl/imem_fetch_unit.sv
// Instruction memory with a valid/ready fetch port and a word-wide program loader.
// Define IMEM_FAULT_EN to report misaligned or out-of-range fetches as faulted NOPs.
module imem_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000013,
  localparam int IDXW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_fault,
  input  logic                  ld_en,
  input  logic                  ld_we,
  input  logic [IDXW-1:0]       ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  busy,
  output logic [31:0]           fetch_count
);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_LOAD  = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic                  rsp_fault_q, rsp_fault_d;
  logic [31:0]           fetch_count_q, fetch_count_d;

  logic                  slot_free;
  logic                  accept;
  logic                  req_fault;
  logic [IDXW-1:0]       req_idx;
  logic                  mem_we;

  assign req_idx = req_addr[IDXW+1:2];

`ifdef IMEM_FAULT_EN
  // Any set bit above the word index means the byte address is past DEPTH*4.
  assign req_fault = (req_addr[1:0] != 2'b00) || (|req_addr[ADDR_WIDTH-1:IDXW+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_WIDTH-1:IDXW+2]};
  assign req_fault        = 1'b0;
`endif

  // The slot can take a new word if it is empty or being consumed this cycle.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign req_ready = (state_q == ST_FETCH) && !ld_en && slot_free;
  assign accept    = req_valid && req_ready;
  assign mem_we    = (state_q == ST_LOAD) && ld_we;

  always_comb begin
    state_d       = state_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_instr_d   = rsp_instr_q;
    rsp_addr_d    = rsp_addr_q;
    rsp_fault_d   = rsp_fault_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_FETCH: if (ld_en && slot_free) state_d = ST_LOAD;
      ST_LOAD:  if (!ld_en)             state_d = ST_FETCH;
      default:                          state_d = ST_FETCH;
    endcase

    if (accept) begin
      rsp_valid_d   = 1'b1;
      rsp_addr_d    = req_addr;
      rsp_fault_d   = req_fault;
      rsp_instr_d   = req_fault ? NOP_WORD : mem[req_idx];
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      rsp_valid_q   <= 1'b0;
      rsp_instr_q   <= '0;
      rsp_addr_q    <= '0;
      rsp_fault_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_instr_q   <= rsp_instr_d;
      rsp_addr_q    <= rsp_addr_d;
      rsp_fault_q   <= rsp_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Program storage keeps its contents across reset; only the loader writes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[ld_addr] <= ld_data;
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_instr   = rsp_instr_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_fault   = rsp_fault_q;
  assign busy        = (state_q == ST_LOAD);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: loads a small program, then fetches it under
// backpressure, loader exclusion, fault and asynchronous-reset scenarios.
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_fault;
  logic        ld_en;
  logic        ld_we;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        busy;
  logic [31:0] fetch_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [512];
  logic [31:0] exp_count = 32'd0;

  imem_fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(512), .NOP_WORD(32'h00000013)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .ld_en(ld_en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Scoreboard: consume at the response handshake, predict at the request handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got instr=%h addr=%h with nothing expected", rsp_instr, rsp_addr);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({rsp_instr, rsp_addr, rsp_fault} !== {e.instr, e.addr, e.fault}) begin
            fails++;
            $display("FAIL sb_rsp: got instr=%h addr=%h fault=%b, expected instr=%h addr=%h fault=%b",
                     rsp_instr, rsp_addr, rsp_fault, e.instr, e.addr, e.fault);
          end
        end
      end
      if (busy && ld_we) model_mem[ld_addr] = ld_data;
      if (req_valid && req_ready) begin
        exp_t n;
        n.addr = req_addr;
`ifdef IMEM_FAULT_EN
        n.fault = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h800);
`else
        n.fault = 1'b0;
`endif
        n.instr = n.fault ? 32'h00000013 : model_mem[req_addr[10:2]];
        sb_q.push_back(n);
        exp_count = exp_count + 32'd1;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    tests++;
    if ({rsp_valid, rsp_fault, busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got valid/fault/busy=%b, expected 000", {rsp_valid, rsp_fault, busy});
    end
    tests++;
    if (rsp_instr !== 32'h0 || rsp_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_rsp: got instr=%h addr=%h, expected 0/0", rsp_instr, rsp_addr);
    end
    tests++;
    if (fetch_count !== 32'h0) begin
      fails++;
      $display("FAIL reset_count: got %0d, expected 0", fetch_count);
    end
    step; step;
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 1", req_ready);
    end
  endtask

  task automatic test_load_fetch;
    ld_en = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL ld_ready: got %b, expected 0", req_ready);
    end
    step;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ld_busy: got %b, expected 1", busy);
    end
    ld_we = 1'b1; ld_addr = 9'd0; ld_data = 32'h004182b3;
    step;
    ld_addr = 9'd1; ld_data = 32'h40418333;
    step;
    ld_we = 1'b0; ld_en = 1'b0;
    step;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL ld_exit_busy: got %b, expected 0", busy);
    end
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL first_ready: got %b, expected 1", req_ready);
    end
    step;
    tests++;
    if (rsp_valid !== 1'b1 || rsp_instr !== 32'h004182b3 || rsp_addr !== 32'h0) begin
      fails++;
      $display("FAIL fetch0: got v=%b instr=%h addr=%h, expected 1/004182b3/0", rsp_valid, rsp_instr, rsp_addr);
    end
    req_addr = 32'h4;
    step;
    tests++;
    if (rsp_instr !== 32'h40418333 || rsp_addr !== 32'h4) begin
      fails++;
      $display("FAIL fetch4: got instr=%h addr=%h, expected 40418333/4", rsp_instr, rsp_addr);
    end
    req_valid = 1'b0;
    step;
    tests++;
    if (rsp_valid !== 1'b0 || fetch_count !== exp_count || exp_count !== 32'd2) begin
      fails++;
      $display("FAIL drain_count: got v=%b count=%0d, expected 0/2 (model %0d)", rsp_valid, fetch_count, exp_count);
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
    step;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_instr !== 32'h40418333) begin
        fails++;
        $display("FAIL stall_%0d: got ready=%b v=%b instr=%h, expected 0/1/40418333", i, req_ready, rsp_valid, rsp_instr);
      end
      step;
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL unstall_ready: got %b, expected 1", req_ready);
    end
    step;
    tests++;
    if (rsp_instr !== 32'h004182b3 || rsp_addr !== 32'h0) begin
      fails++;
      $display("FAIL unstall_rsp: got instr=%h addr=%h, expected 004182b3/0", rsp_instr, rsp_addr);
    end
    req_valid = 1'b0;
    step;
  endtask

  task automatic test_loader_exclusion;
    req_valid = 1'b1; req_addr = 32'h0; ld_en = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL excl_ready: got %b, expected 0", req_ready);
    end
    step;
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL excl_busy: got busy=%b v=%b, expected 1/0", busy, rsp_valid);
    end
    req_valid = 1'b0; ld_we = 1'b1; ld_addr = 9'd3; ld_data = 32'h0041c433;
    step;
    ld_we = 1'b0; ld_en = 1'b0;
    step;
    // A write strobe outside LOAD must not reach the array.
    ld_we = 1'b1; ld_addr = 9'd3; ld_data = 32'hdeadbeef;
    step;
    ld_we = 1'b0; req_valid = 1'b1; req_addr = 32'hC;
    step;
    req_valid = 1'b0;
    tests++;
    if (rsp_instr !== 32'h0041c433 || rsp_addr !== 32'hC) begin
      fails++;
      $display("FAIL excl_fetch: got instr=%h addr=%h, expected 0041c433/c", rsp_instr, rsp_addr);
    end
    step;
  endtask

  task automatic test_fault;
    logic [31:0] exp_i;
    logic        exp_f;
`ifdef IMEM_FAULT_EN
    exp_i = 32'h00000013; exp_f = 1'b1;
`else
    exp_i = 32'h004182b3; exp_f = 1'b0;
`endif
    req_valid = 1'b1; req_addr = 32'h800;
    step;
    tests++;
    if (rsp_instr !== exp_i || rsp_fault !== exp_f) begin
      fails++;
      $display("FAIL fault_range: got instr=%h fault=%b, expected %h/%b", rsp_instr, rsp_fault, exp_i, exp_f);
    end
    req_addr = 32'h2;
    step;
    tests++;
    if (rsp_instr !== exp_i || rsp_fault !== exp_f || rsp_addr !== 32'h2) begin
      fails++;
      $display("FAIL fault_align: got instr=%h fault=%b addr=%h, expected %h/%b/2", rsp_instr, rsp_fault, rsp_addr, exp_i, exp_f);
    end
    req_addr = 32'h4;
    step;
    req_valid = 1'b0;
    tests++;
    if (rsp_instr !== 32'h40418333 || rsp_fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_clear: got instr=%h fault=%b, expected 40418333/0", rsp_instr, rsp_fault);
    end
    step;
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [4];
    addrs[0] = 32'hC; addrs[1] = 32'h0; addrs[2] = 32'h4; addrs[3] = 32'hC;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = addrs[i];
      step;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_addr !== addrs[i]) begin
        fails++;
        $display("FAIL b2b_%0d: got v=%b addr=%h, expected 1/%h", i, rsp_valid, rsp_addr, addrs[i]);
      end
    end
    req_valid = 1'b0;
    step;
  endtask

  task automatic test_async_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb_q.delete();
    exp_count = 32'd0;
    step;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 32'(i % 2) * 32'h4;
      step;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    step;
    tests++;
    if (fetch_count !== 32'd5 || rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got count=%0d v=%b, expected 5/1", fetch_count, rsp_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || fetch_count !== 32'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got v=%b count=%0d busy=%b, expected 0/0/0", rsp_valid, fetch_count, busy);
    end
    sb_q.delete();
    exp_count = 32'd0;
    step;
    rst_n = 1'b1; rsp_ready = 1'b1;
    step;
    req_valid = 1'b1; req_addr = 32'h4;
    step;
    req_valid = 1'b0;
    tests++;
    if (rsp_instr !== 32'h40418333 || fetch_count !== 32'd1) begin
      fails++;
      $display("FAIL post_reset_mem: got instr=%h count=%0d, expected 40418333/1", rsp_instr, fetch_count);
    end
    step;
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_loader_exclusion();
    test_fault();
    test_back_to_back();
    test_async_reset();
    step;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending responses, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
